// File: rtl/id_ex_pipeline_reg.sv
// id_ex_pipeline_reg: ID/EX pipeline register with hold, bubble/flush NOP insertion and a saturating bubble counter
module id_ex_pipeline_reg #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              hold,
  input  logic              bubble,
  input  logic              flush,
  input  logic              id_valid,
  input  logic              id_alusrc,
  input  logic              id_regdest,
  input  logic              id_readdmem,
  input  logic              id_writedmem,
  input  logic              id_regwrite,
  input  logic              id_memtoreg,
  input  logic [3:0]        id_alufunc,
  input  logic [DATA_W-1:0] id_pc,
  input  logic [DATA_W-1:0] id_rs_data,
  input  logic [DATA_W-1:0] id_rt_data,
  input  logic [DATA_W-1:0] id_imm,
  input  logic [4:0]        id_rs_addr,
  input  logic [4:0]        id_rt_addr,
  input  logic [4:0]        id_rd_addr,
  output logic              ex_valid,
  output logic              ex_alusrc,
  output logic              ex_regdest,
  output logic              ex_readdmem,
  output logic              ex_writedmem,
  output logic              ex_regwrite,
  output logic              ex_memtoreg,
  output logic [3:0]        ex_alufunc,
  output logic [DATA_W-1:0] ex_pc,
  output logic [DATA_W-1:0] ex_rs_data,
  output logic [DATA_W-1:0] ex_rt_data,
  output logic [DATA_W-1:0] ex_imm,
  output logic [4:0]        ex_rs_addr,
  output logic [4:0]        ex_rt_addr,
  output logic [4:0]        ex_wr_addr,
  output logic [CNT_W-1:0]  bubble_count
);
  typedef struct packed {
    logic              valid;
    logic              alusrc;
    logic              regdest;
    logic              readdmem;
    logic              writedmem;
    logic              regwrite;
    logic              memtoreg;
    logic [3:0]        alufunc;
    logic [DATA_W-1:0] pc;
    logic [DATA_W-1:0] rs_data;
    logic [DATA_W-1:0] rt_data;
    logic [DATA_W-1:0] imm;
    logic [4:0]        rs_addr;
    logic [4:0]        rt_addr;
    logic [4:0]        wr_addr;
  } ex_t;
  ex_t              r_ex;
  ex_t              w_load;
  logic [CNT_W-1:0] r_cnt;
  logic             w_nop;
  always_comb begin
    w_load = '{
      valid:     id_valid,
      alusrc:    id_alusrc,
      regdest:   id_regdest,
      readdmem:  id_readdmem & id_valid,
      writedmem: id_writedmem & id_valid,
      regwrite:  id_regwrite & id_valid,
      memtoreg:  id_memtoreg,
      alufunc:   id_alufunc,
      pc:        id_pc,
      rs_data:   id_rs_data,
      rt_data:   id_rt_data,
      imm:       id_imm,
      rs_addr:   id_rs_addr,
      rt_addr:   id_rt_addr,
      wr_addr:   id_regdest ? id_rd_addr : id_rt_addr
    };
    w_nop = flush | (bubble & ~hold);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ex  <= '0;
      r_cnt <= '0;
    end else if (w_nop) begin
      r_ex  <= '0;
      r_cnt <= &r_cnt ? r_cnt : r_cnt + CNT_W'(1);
    end else if (!hold) begin
      r_ex  <= w_load;
    end
  end
  assign ex_valid     = r_ex.valid;
  assign ex_alusrc    = r_ex.alusrc;
  assign ex_regdest   = r_ex.regdest;
  assign ex_readdmem  = r_ex.readdmem;
  assign ex_writedmem = r_ex.writedmem;
  assign ex_regwrite  = r_ex.regwrite;
  assign ex_memtoreg  = r_ex.memtoreg;
  assign ex_alufunc   = r_ex.alufunc;
  assign ex_pc        = r_ex.pc;
  assign ex_rs_data   = r_ex.rs_data;
  assign ex_rt_data   = r_ex.rt_data;
  assign ex_imm       = r_ex.imm;
  assign ex_rs_addr   = r_ex.rs_addr;
  assign ex_rt_addr   = r_ex.rt_addr;
  assign ex_wr_addr   = r_ex.wr_addr;
  assign bubble_count = r_cnt;
endmodule

// File: tb/tb_id_ex_pipeline_reg.sv
// tb_id_ex_pipeline_reg: directed vectors with hand-computed expectations, plus a CNT_W=2 instance for saturation
module tb_id_ex_pipeline_reg;
  logic        clk = 0;
  logic        rst, hold, bubble, flush;
  logic        id_valid, id_alusrc, id_regdest, id_readdmem, id_writedmem, id_regwrite, id_memtoreg;
  logic [3:0]  id_alufunc;
  logic [31:0] id_pc, id_rs_data, id_rt_data, id_imm;
  logic [4:0]  id_rs_addr, id_rt_addr, id_rd_addr;
  logic        ex_valid, ex_alusrc, ex_regdest, ex_readdmem, ex_writedmem, ex_regwrite, ex_memtoreg;
  logic [3:0]  ex_alufunc;
  logic [31:0] ex_pc, ex_rs_data, ex_rt_data, ex_imm;
  logic [4:0]  ex_rs_addr, ex_rt_addr, ex_wr_addr;
  logic [15:0] bubble_count;
  logic        s_valid, s_alusrc, s_regdest, s_readdmem, s_writedmem, s_regwrite, s_memtoreg;
  logic [3:0]  s_alufunc;
  logic [31:0] s_pc, s_rs_data, s_rt_data, s_imm;
  logic [4:0]  s_rs_addr, s_rt_addr, s_wr_addr;
  logic [1:0]  s_count;
  int          n_vec = 0;
  int          n_err = 0;
  always #5 clk = ~clk;
  id_ex_pipeline_reg u_dut (
    .clk(clk), .rst(rst), .hold(hold), .bubble(bubble), .flush(flush),
    .id_valid(id_valid), .id_alusrc(id_alusrc), .id_regdest(id_regdest), .id_readdmem(id_readdmem),
    .id_writedmem(id_writedmem), .id_regwrite(id_regwrite), .id_memtoreg(id_memtoreg), .id_alufunc(id_alufunc),
    .id_pc(id_pc), .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
    .id_rs_addr(id_rs_addr), .id_rt_addr(id_rt_addr), .id_rd_addr(id_rd_addr),
    .ex_valid(ex_valid), .ex_alusrc(ex_alusrc), .ex_regdest(ex_regdest), .ex_readdmem(ex_readdmem),
    .ex_writedmem(ex_writedmem), .ex_regwrite(ex_regwrite), .ex_memtoreg(ex_memtoreg), .ex_alufunc(ex_alufunc),
    .ex_pc(ex_pc), .ex_rs_data(ex_rs_data), .ex_rt_data(ex_rt_data), .ex_imm(ex_imm),
    .ex_rs_addr(ex_rs_addr), .ex_rt_addr(ex_rt_addr), .ex_wr_addr(ex_wr_addr), .bubble_count(bubble_count)
  );
  id_ex_pipeline_reg #(.DATA_W(32), .CNT_W(2)) u_sat (
    .clk(clk), .rst(rst), .hold(hold), .bubble(bubble), .flush(flush),
    .id_valid(id_valid), .id_alusrc(id_alusrc), .id_regdest(id_regdest), .id_readdmem(id_readdmem),
    .id_writedmem(id_writedmem), .id_regwrite(id_regwrite), .id_memtoreg(id_memtoreg), .id_alufunc(id_alufunc),
    .id_pc(id_pc), .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
    .id_rs_addr(id_rs_addr), .id_rt_addr(id_rt_addr), .id_rd_addr(id_rd_addr),
    .ex_valid(s_valid), .ex_alusrc(s_alusrc), .ex_regdest(s_regdest), .ex_readdmem(s_readdmem),
    .ex_writedmem(s_writedmem), .ex_regwrite(s_regwrite), .ex_memtoreg(s_memtoreg), .ex_alufunc(s_alufunc),
    .ex_pc(s_pc), .ex_rs_data(s_rs_data), .ex_rt_data(s_rt_data), .ex_imm(s_imm),
    .ex_rs_addr(s_rs_addr), .ex_rt_addr(s_rt_addr), .ex_wr_addr(s_wr_addr), .bubble_count(s_count)
  );
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  initial begin
    rst = 1; hold = 0; bubble = 0; flush = 0;
    {id_valid, id_alusrc, id_regdest, id_readdmem, id_writedmem, id_regwrite, id_memtoreg} = '1;
    id_alufunc = '1; id_pc = '1; id_rs_data = '1; id_rt_data = '1; id_imm = '1;
    id_rs_addr = '1; id_rt_addr = '1; id_rd_addr = '1;
    step();
    step();
    chk("rst_valid", ex_valid, 0);
    chk("rst_regwrite", ex_regwrite, 0);
    chk("rst_memtoreg", ex_memtoreg, 0);
    chk("rst_alufunc", ex_alufunc, 0);
    chk("rst_pc", ex_pc, 0);
    chk("rst_imm", ex_imm, 0);
    chk("rst_wr_addr", ex_wr_addr, 0);
    chk("rst_count", bubble_count, 0);
    chk("rst_scount", s_count, 0);
    rst = 0;
    {id_valid, id_alusrc, id_regdest, id_readdmem, id_writedmem, id_regwrite, id_memtoreg} = 7'b1110010;
    id_alufunc = 4'h2; id_pc = 32'h40; id_rs_data = 5; id_rt_data = 7; id_imm = 32'hfffffff0;
    id_rs_addr = 5'd1; id_rt_addr = 5'd3; id_rd_addr = 5'd9;
    step();
    chk("ld_pc", ex_pc, 32'h40);
    chk("ld_wr_addr", ex_wr_addr, 9);
    chk("ld_regwrite", ex_regwrite, 1);
    chk("ld_alufunc", ex_alufunc, 2);
    chk("ld_valid", ex_valid, 1);
    chk("ld_rs_data", ex_rs_data, 5);
    chk("ld_rt_data", ex_rt_data, 7);
    chk("ld_imm", ex_imm, 32'hfffffff0);
    chk("ld_alusrc", ex_alusrc, 1);
    chk("ld_memtoreg", ex_memtoreg, 0);
    chk("ld_rs_addr", ex_rs_addr, 1);
    chk("ld_rt_addr", ex_rt_addr, 3);
    id_regdest = 0; id_memtoreg = 1;
    step();
    chk("ld_rt_dest", ex_wr_addr, 3);
    chk("ld_regdest0", ex_regdest, 0);
    chk("ld_memtoreg1", ex_memtoreg, 1);
    id_regdest = 1; id_memtoreg = 0;
    step();
    chk("ld_rd_dest", ex_wr_addr, 9);
    hold = 1; id_pc = 32'h44;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("hold_pc", ex_pc, 32'h40);
      chk("hold_valid", ex_valid, 1);
    end
    bubble = 1;
    step();
    chk("hold_bub_pc", ex_pc, 32'h40);
    chk("hold_bub_valid", ex_valid, 1);
    chk("hold_bub_count", bubble_count, 0);
    hold = 0; id_readdmem = 1;
    step();
    chk("bub_valid", ex_valid, 0);
    chk("bub_readdmem", ex_readdmem, 0);
    chk("bub_regwrite", ex_regwrite, 0);
    chk("bub_alufunc", ex_alufunc, 0);
    chk("bub_pc", ex_pc, 0);
    chk("bub_wr_addr", ex_wr_addr, 0);
    chk("bub_count", bubble_count, 1);
    bubble = 0;
    step();
    chk("reload_pc", ex_pc, 32'h44);
    chk("reload_valid", ex_valid, 1);
    chk("reload_readdmem", ex_readdmem, 1);
    chk("reload_count", bubble_count, 1);
    hold = 1; flush = 1;
    step();
    chk("flhold_valid", ex_valid, 0);
    chk("flhold_pc", ex_pc, 0);
    chk("flhold_count", bubble_count, 2);
    hold = 0; bubble = 1;
    step();
    chk("flbub_count", bubble_count, 3);
    chk("flbub_scount", s_count, 3);
    flush = 0;
    for (int i = 0; i < 2; i++) begin
      step();
      chk("sat_scount", s_count, 3);
    end
    chk("sat_count", bubble_count, 5);
    bubble = 0; id_valid = 0; id_regwrite = 1; id_writedmem = 1; id_readdmem = 1;
    step();
    chk("inv_regwrite", ex_regwrite, 0);
    chk("inv_writedmem", ex_writedmem, 0);
    chk("inv_readdmem", ex_readdmem, 0);
    chk("inv_valid", ex_valid, 0);
    chk("inv_pc", ex_pc, 32'h44);
    chk("inv_count", bubble_count, 5);
    id_valid = 1; rst = 1; flush = 1;
    step();
    chk("rst2_pc", ex_pc, 0);
    chk("rst2_valid", ex_valid, 0);
    chk("rst2_count", bubble_count, 0);
    rst = 0; flush = 0;
    step();
    chk("post_rst_pc", ex_pc, 32'h44);
    chk("post_rst_writedmem", ex_writedmem, 1);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
